// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX serializer between NREQ producers; optional watchdog under UART_TX_ARB_TIMEOUT_EN
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int NBITS = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*NBITS-1:0] i_data,
  output logic [NREQ-1:0]       o_gnt,
  output logic                  o_tx_start,
  output logic [NBITS-1:0]      o_tx_data,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic [OW-1:0]         o_owner,
  output logic                  o_timeout
);
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) $error("uart_tx_arbiter: bad parameters");
  state_t state, state_n;
  logic [OW-1:0] ptr, ptr_n, win, owner_n;
  logic found, start_n, busy_n;
  logic [NREQ-1:0] gnt_n;
  logic [NBITS-1:0] data_n;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WW-1:0] wd, wd_n;
  logic to_n;
`else
  assign o_timeout = 1'b0;
`endif
  // first requester at or after the pointer, wrapping; scanned backwards so the nearest one wins
  always_comb begin
    int k;
    win = '0;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NREQ;
      if (i_req[OW'(k)]) begin
        win = OW'(k);
        found = 1'b1;
      end
    end
  end
  // sequencing: grant and start in one shot, then follow done low and back high
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    gnt_n = '0;
    start_n = 1'b0;
    busy_n = o_busy;
    data_n = o_tx_data;
    owner_n = o_owner;
    case (state)
      IDLE: if (found && i_tx_done) begin
        state_n = START;
        ptr_n = (win == OW'(NREQ - 1)) ? '0 : win + 1'b1;
        gnt_n[win] = 1'b1;
        start_n = 1'b1;
        busy_n = 1'b1;
        data_n = i_data[win*NBITS +: NBITS];
        owner_n = win;
      end
      START: state_n = WAIT_BUSY;
      WAIT_BUSY: state_n = i_tx_done ? WAIT_BUSY : WAIT_DONE;
      WAIT_DONE: if (i_tx_done) begin
        state_n = IDLE;
        busy_n = 1'b0;
      end
    endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
    to_n = 1'b0;
    wd_n = (state == WAIT_BUSY || state == WAIT_DONE) ? wd + 1'b1 : '0;
    if ((state == WAIT_BUSY || state == WAIT_DONE) && state_n == state && wd == WW'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      busy_n = 1'b0;
      to_n = 1'b1;
    end
`endif
  end
  // all state and outputs registered; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      o_gnt <= '0;
      o_tx_start <= 1'b0;
      o_tx_data <= '0;
      o_busy <= 1'b0;
      o_owner <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd <= '0;
      o_timeout <= 1'b0;
`endif
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      o_gnt <= gnt_n;
      o_tx_start <= start_n;
      o_tx_data <= data_n;
      o_busy <= busy_n;
      o_owner <= owner_n;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd <= wd_n;
      o_timeout <= to_n;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a transaction-level arbitration model and a serializer stand-in
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int NBITS = 8;
  localparam int TO = 16;
  typedef struct {int owner; logic [NBITS-1:0] data;} txn_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] i_req = '0;
  logic [NREQ*NBITS-1:0] i_data = '0;
  logic i_tx_done = 1'b1;
  logic [NREQ-1:0] o_gnt;
  logic o_tx_start, o_busy, o_timeout;
  logic [NBITS-1:0] o_tx_data;
  logic [1:0] o_owner;
  int checks = 0;
  int failures = 0;
  txn_t exp_q[$];
  int got_q[$];
  logic [NBITS-1:0] got_d[$];
  int m_ptr, m_phase, m_wait;
  bit m_active, m_start, m_to;
  logic [NREQ-1:0] hold;
  bit rnd, gate, stuck, arm_stuck;
  int ser_len, ser_cnt;
  logic [NBITS-1:0] held;
  txn_t t;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_data(i_data), .o_gnt(o_gnt),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_done(i_tx_done),
    .o_busy(o_busy), .o_owner(o_owner), .o_timeout(o_timeout)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: one transfer at a time; a new one starts when the serializer is idle and someone asks
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ptr = 0; m_active = 0; m_start = 0; m_to = 0; m_phase = 0; m_wait = 0;
      exp_q.delete();
    end else begin
      int w;
      bit ex;
      m_start = 0;
      m_to = 0;
      if (!m_active) begin
        if (i_tx_done && |i_req) begin
          w = m_ptr;
          while (!i_req[w]) w = (w + 1) % NREQ;
          exp_q.push_back('{w, i_data[w*NBITS +: NBITS]});
          m_ptr = (w + 1) % NREQ;
          m_active = 1; m_start = 1; m_phase = 0; m_wait = 0;
        end
      end else if (m_phase == 0) m_phase = 1;
      else begin
        ex = (m_phase == 1) ? !i_tx_done : i_tx_done;
`ifdef UART_TX_ARB_TIMEOUT_EN
        if (!ex && m_wait == TO - 1) begin m_active = 0; m_to = 1; end else
`endif
        if (ex) begin
          if (m_phase == 2) m_active = 0; else m_phase = 2;
        end
        m_wait++;
      end
    end
  end

  // monitor: compare every cycle, pop the expected transfer whenever a start is due
  always @(negedge clk) if (rst) begin
    check("busy", o_busy, m_active);
    check("timeout", o_timeout, m_to);
    check("start", o_tx_start, m_start);
    if (o_tx_start) begin
      got_q.push_back(int'(o_owner));
      got_d.push_back(o_tx_data);
    end
    if (m_start && exp_q.size() > 0) begin
      t = exp_q.pop_front();
      check("gnt", o_gnt, 64'(1) << t.owner);
      check("owner", o_owner, t.owner);
      check("tx_data", o_tx_data, t.data);
      held = t.data;
    end else begin
      check("gnt_quiet", o_gnt, 0);
      if (o_busy) check("data_hold", o_tx_data, held);
    end
  end

  task automatic cyc();
    @(negedge clk);
    if (o_tx_start) ser_cnt = ser_len; else if (ser_cnt > 0) ser_cnt--;
    if (o_tx_start && arm_stuck) begin stuck = 1; arm_stuck = 0; end
    if (o_timeout) stuck = 0;
    i_tx_done = !(gate || stuck || ser_cnt > 0);
    for (int k = 0; k < NREQ; k++)
      if (o_gnt[k] && !hold[k]) begin
        if (rnd && $urandom_range(1) == 1) i_data[k*NBITS +: NBITS] = 8'($urandom);
        else i_req[k] = 1'b0;
      end
    if (rnd)
      for (int k = 0; k < NREQ; k++)
        if (!i_req[k] && $urandom_range(3) == 0) begin
          i_data[k*NBITS +: NBITS] = 8'($urandom);
          i_req[k] = 1'b1;
        end
  endtask

  task automatic wait_idle(int max);
    int n = 0;
    do cyc(); while (o_busy && ++n < max);
    check("idle_bound", o_busy, 0);
  endtask

  task automatic wait_start(int max);
    int n = 0;
    do cyc(); while (!o_tx_start && ++n < max);
    check("start_bound", o_tx_start, 1);
  endtask

  task automatic wait_grants(int cnt, int max);
    int n = 0;
    while (got_q.size() < cnt && n < max) begin cyc(); n++; end
    check("grant_bound", got_q.size() >= cnt, 1);
  endtask

  task automatic chk_reset(string tag);
    #1;
    check({tag, "_gnt"}, o_gnt, 0);
    check({tag, "_start"}, o_tx_start, 0);
    check({tag, "_data"}, o_tx_data, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_owner"}, o_owner, 0);
    check({tag, "_timeout"}, o_timeout, 0);
  endtask

  initial begin
    int pulses;
    hold = '0; rnd = 0; gate = 0; stuck = 0; arm_stuck = 0; ser_len = 4; ser_cnt = 0;
    #1 rst = 1'b0;
    chk_reset("por");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ser_len = 160;
    i_data[2*NBITS +: NBITS] = 8'hA5;
    i_req = 4'b0100;
    cyc();
    check("single_start", o_tx_start, 1);
    check("single_gnt", o_gnt, 4'b0100);
    check("single_data", o_tx_data, 8'hA5);
    check("single_owner", o_owner, 2);
    cyc();
    check("single_start_width", o_tx_start, 0);
    check("single_busy", o_busy, 1);
    wait_idle(400);
    ser_len = 50;
    i_data[1*NBITS +: NBITS] = 8'h3C;
    i_req = 4'b0010;
    wait_start(10);
    repeat (5) cyc();
    check("mid_busy", o_busy, 1);
    rst = 1'b0;
    i_req = '0;
    ser_cnt = 0;
    i_tx_done = 1'b1;
    chk_reset("mid");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ser_len = 3;
    got_q.delete(); got_d.delete();
    hold = '1;
    for (int k = 0; k < NREQ; k++) i_data[k*NBITS +: NBITS] = 8'(8'h10 + k);
    i_req = '1;
    wait_grants(5, 500);
    i_req = '0;
    hold = '0;
    wait_idle(50);
    check("rr_count", got_q.size(), 5);
    if (got_q.size() >= 5)
      for (int i = 0; i < 5; i++) begin
        check("rr_order", got_q[i], i % 4);
        check("rr_byte", got_d[i], 8'(8'h10 + i % 4));
      end
    i_data[2*NBITS +: NBITS] = 8'h22;
    i_req = 4'b0100;
    wait_start(10);
    wait_idle(50);
    got_q.delete();
    i_data[3*NBITS +: NBITS] = 8'h33;
    i_data[0 +: NBITS] = 8'h30;
    i_req = 4'b1001;
    wait_grants(2, 100);
    wait_idle(50);
    check("wrap_first", got_q[0], 3);
    check("wrap_second", got_q[1], 0);
    got_q.delete();
    gate = 1;
    cyc();
    i_data[0 +: NBITS] = 8'h44;
    i_req = 4'b0001;
    repeat (6) cyc();
    check("gate_nogrant", got_q.size(), 0);
    check("gate_idle", o_busy, 0);
    gate = 0;
    cyc();
    cyc();
    check("gate_release_start", o_tx_start, 1);
    check("gate_release_gnt", o_gnt, 4'b0001);
    wait_idle(50);
`ifdef UART_TX_ARB_TIMEOUT_EN
    got_q.delete();
    arm_stuck = 1;
    i_data[0 +: NBITS] = 8'h50;
    i_data[1*NBITS +: NBITS] = 8'h51;
    i_req = 4'b0011;
    pulses = 0;
    repeat (60) begin
      cyc();
      if (o_timeout) begin
        pulses++;
        check("timeout_busy", o_busy, 0);
      end
    end
    check("timeout_pulses", pulses, 1);
    wait_idle(50);
    check("timeout_grants", got_q.size(), 2);
    check("timeout_first", got_q[0], 1);
    check("timeout_next", got_q[1], 0);
`endif
    rnd = 1;
    repeat (2000) begin
      ser_len = $urandom_range(8, 2);
      cyc();
    end
    rnd = 0;
    i_req = '0;
    wait_idle(50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
